// File: rtl/mpu_operand_stage_pkg.sv
// Shared opcodes, lane sizes, stage state encoding and lane helper functions
// for the MPU operand stage.
package mpu_operand_stage_pkg;

  typedef enum logic [3:0] {
    MPU_OP_NONE = 4'd0,
    MPU_OP_MASK = 4'd1,
    MPU_OP_CMP  = 4'd2,
    MPU_OP_LT   = 4'd3,
    MPU_OP_ADD  = 4'd4,
    MPU_OP_HAMM = 4'd5
  } mpu_op_e;

  localparam logic [1:0] MPU_SIZE_B  = 2'd0;
  localparam logic [1:0] MPU_SIZE_W  = 2'd1;
  localparam logic [1:0] MPU_SIZE_DW = 2'd2;
  localparam logic [1:0] MPU_SIZE_QW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } stage_state_e;

  // Only the defined result-producing ops write back and update flags.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= MPU_OP_MASK) && (op <= MPU_OP_HAMM);
  endfunction

  // Lane offset in bytes is sres<<size; anything past byte 7 lies outside
  // the 64-bit register.
  function automatic logic lane_illegal(input logic [1:0] size, input logic [2:0] sres);
    logic [5:0] boff;
    boff = {3'b000, sres} << size;
    return boff >= 6'd8;
  endfunction

  // Byte-enable mask of the destination lane (lanes are whole bytes).
  function automatic logic [7:0] lane_bmask(input logic [1:0] size, input logic [2:0] sres);
    logic [7:0]  ones;
    logic [15:0] m;
    case (size)
      MPU_SIZE_B:  ones = 8'h01;
      MPU_SIZE_W:  ones = 8'h03;
      MPU_SIZE_DW: ones = 8'h0F;
      default:     ones = 8'hFF;
    endcase
    m = {8'h00, ones} << ({3'b000, sres} << size);
    return m[7:0];
  endfunction

endpackage

// File: rtl/mpu_operand_stage_regfile.sv
// NREG x 64 register file: four combinational operand reads, a byte-masked
// writeback port, a full-word host write port and a registered host read.
module mpu_operand_stage_regfile
  import mpu_operand_stage_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0][AW-1:0]   rd_addr,
  output logic [3:0][63:0]     rd_data,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [7:0]           wb_bmask,
  input  logic [63:0]          wb_data,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_addr,
  input  logic [63:0]          host_wdata,
  output logic [63:0]          host_rdata
);

  logic [NREG-1:0][63:0] regs;

  // Register array update; host and writeback never collide because the
  // host port is blocked during writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wb_we && (wb_addr == AW'(r))) begin
          for (int b = 0; b < 8; b++) begin
            if (wb_bmask[b]) regs[r][8*b +: 8] <= wb_data[8*b +: 8];
          end
        end
        if (host_we && (host_addr == AW'(r))) regs[r] <= host_wdata;
      end
    end
  end

  // Operand read ports see the pre-edge contents.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 4; i++) rd_data[i] = regs[rd_addr[i]];
  end

  // Host readback, one cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rdata <= '0;
    else        host_rdata <= regs[host_addr];
  end

endmodule

// File: rtl/mpu_operand_stage.sv
// Issue/operand stage in front of the MPU ALU: accepts an instruction,
// reads operands, hands them to the ALU and merges the result back.
module mpu_operand_stage
  import mpu_operand_stage_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic [1:0]     in_size,
  input  logic [AW-1:0]  in_r0,
  input  logic [AW-1:0]  in_r1,
  input  logic [AW-1:0]  in_r2,
  input  logic [AW-1:0]  in_r3,
  input  logic [2:0]     in_s0,
  input  logic [2:0]     in_s1,
  input  logic [2:0]     in_s2,
  input  logic [2:0]     in_s3,
  input  logic [AW-1:0]  in_rd,
  input  logic [2:0]     in_sres,
  output logic [3:0]     alu_op,
  output logic [1:0]     alu_size,
  output logic [63:0]    alu_o0,
  output logic [63:0]    alu_o1,
  output logic [63:0]    alu_o2,
  output logic [63:0]    alu_o3,
  output logic [2:0]     alu_s0,
  output logic [2:0]     alu_s1,
  output logic [2:0]     alu_s2,
  output logic [2:0]     alu_s3,
  output logic [2:0]     alu_sres,
  input  logic [63:0]    alu_res,
  input  logic [7:0]     alu_flags,
  input  logic           host_we,
  output logic           host_ready,
  input  logic [AW-1:0]  host_addr,
  input  logic [63:0]    host_wdata,
  output logic [63:0]    host_rdata,
  output logic [7:0]     flags,
  output logic           done,
  output logic           err
);

  typedef struct packed {
    logic [3:0]          op;
    logic [1:0]          size;
    logic [3:0][AW-1:0]  rs;
    logic [3:0][2:0]     sel;
    logic [AW-1:0]       rd;
    logic [2:0]          sres;
  } req_t;

  stage_state_e        state;
  req_t                req_q;
  logic [63:0]         res_q;
  logic [3:0][AW-1:0]  rd_addr;
  logic [3:0][63:0]    rd_data;
  logic                wb_illegal;
  logic                wb_we;
  logic [7:0]          wb_bmask;

  assign rd_addr    = req_q.rs;
  assign wb_illegal = lane_illegal(req_q.size, req_q.sres);
  assign wb_bmask   = lane_bmask(req_q.size, req_q.sres);
  assign wb_we      = (state == ST_WB) && op_writes(req_q.op) && !wb_illegal;

  mpu_operand_stage_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wb_we      (wb_we),
    .wb_addr    (req_q.rd),
    .wb_bmask   (wb_bmask),
    .wb_data    (res_q),
    .host_we    (host_we && host_ready),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  // Four-state issue sequence with all handshake and ALU outputs registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      res_q      <= '0;
      flags      <= '0;
      alu_op     <= '0;
      alu_size   <= '0;
      alu_o0     <= '0;
      alu_o1     <= '0;
      alu_o2     <= '0;
      alu_o3     <= '0;
      alu_s0     <= '0;
      alu_s1     <= '0;
      alu_s2     <= '0;
      alu_s3     <= '0;
      alu_sres   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      in_ready   <= 1'b1;
      host_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            req_q.op   <= in_op;
            req_q.size <= in_size;
            req_q.rs   <= {in_r3, in_r2, in_r1, in_r0};
            req_q.sel  <= {in_s3, in_s2, in_s1, in_s0};
            req_q.rd   <= in_rd;
            req_q.sres <= in_sres;
            in_ready   <= 1'b0;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          alu_op   <= req_q.op;
          alu_size <= req_q.size;
          alu_o0   <= rd_data[0];
          alu_o1   <= rd_data[1];
          alu_o2   <= rd_data[2];
          alu_o3   <= rd_data[3];
          alu_s0   <= req_q.sel[0];
          alu_s1   <= req_q.sel[1];
          alu_s2   <= req_q.sel[2];
          alu_s3   <= req_q.sel[3];
          alu_sres <= req_q.sres;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q <= alu_res;
          if (op_writes(req_q.op)) flags <= alu_flags;
          host_ready <= 1'b0;
          state      <= ST_WB;
        end
        ST_WB: begin
          done       <= 1'b1;
          err        <= wb_illegal;
          in_ready   <= 1'b1;
          host_ready <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
